// File: rtl/snn_soc_pkg.sv
// Shared SoC constants for the SNN array control chain and the WL DAC path.
package snn_soc_pkg;

  localparam int unsigned NUM_INPUTS       = 64;
  localparam int unsigned WL_SHIFT_WIDTH   = 8;
  localparam int unsigned WL_SETTLE_CYCLES = 4;

  // The bitmap must split into whole shift beats.
  localparam bit WL_SHIFT_DIVIDES = (NUM_INPUTS % WL_SHIFT_WIDTH) == 0;

endpackage

// File: rtl/wl_dac_responder_if.sv
// DAC valid/ready handshake between the WL DAC controller and the responder.
interface wl_dac_responder_if #(
  parameter int unsigned NUM_INPUTS = snn_soc_pkg::NUM_INPUTS
) ();

  logic                  dac_valid;
  logic                  dac_ready;
  logic [NUM_INPUTS-1:0] wl_spike;

  modport master (output dac_valid, output wl_spike, input dac_ready);
  modport slave  (input dac_valid, input wl_spike, output dac_ready);

endinterface

// File: rtl/wl_dac_responder_serializer.sv
// wl_chunk_serializer: holds the accepted bitmap and walks it LSB chunk first.
module wl_chunk_serializer
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = snn_soc_pkg::NUM_INPUTS,
  parameter int unsigned SHIFT_WIDTH = snn_soc_pkg::WL_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic [NUM_INPUTS-1:0]  bitmap_i,
  output logic [SHIFT_WIDTH-1:0] first_chunk_o,
  output logic [SHIFT_WIDTH-1:0] next_chunk_o,
  output logic                   last_o
);

  localparam int unsigned NUM_CHUNKS = NUM_INPUTS / SHIFT_WIDTH;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  logic [NUM_INPUTS-1:0] bitmap_q, bitmap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      nidx;

  assign nidx          = idx_q + IDX_W'(1);
  assign first_chunk_o = bitmap_i[SHIFT_WIDTH-1:0];
  assign next_chunk_o  = bitmap_q[32'(nidx) * SHIFT_WIDTH +: SHIFT_WIDTH];
  assign last_o        = (idx_q == IDX_W'(NUM_CHUNKS - 1));

  // Load restarts at chunk 0; advance steps to the chunk just presented.
  always_comb begin
    bitmap_d = bitmap_q;
    idx_d    = idx_q;
    if (load_i) begin
      bitmap_d = bitmap_i;
      idx_d    = '0;
    end else if (advance_i) begin
      idx_d = nidx;
    end
  end

  // Bitmap copy and chunk index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '0;
      idx_q    <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/wl_dac_responder.sv
// Responder for the WL DAC handshake: serializes the WL bitmap onto the
// driver shift chain, strobes the latch, then waits a settle window.
// Optional feature macro: WL_DAC_REUSE_EN (skip the shift when the bitmap repeats).
module wl_dac_responder
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS    = snn_soc_pkg::NUM_INPUTS,
  parameter int unsigned SHIFT_WIDTH   = snn_soc_pkg::WL_SHIFT_WIDTH,
  parameter int unsigned SETTLE_CYCLES = snn_soc_pkg::WL_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wl_dac_responder_if.slave      dac,
  output logic [SHIFT_WIDTH-1:0] drv_sdata,
  output logic                   drv_sclk,
  output logic                   drv_latch,
  output logic                   drv_busy,
  output logic                   drv_reuse_hit
);

  if (((NUM_INPUTS % SHIFT_WIDTH) != 0) || !WL_SHIFT_DIVIDES || (SETTLE_CYCLES > 255)) begin : g_bad_cfg
    $error("wl_dac_responder: bitmap must split into whole chunks and settle must fit 8 bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH, ST_SETTLE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [SHIFT_WIDTH-1:0] sdata_q, sdata_d;
  logic                   sclk_q, sclk_d;
  logic                   latch_q, latch_d;
  logic                   hit_q, hit_d;
  logic                   reuse_q, reuse_d;
  logic [7:0]             cnt_q, cnt_d;

  logic                   accept, load, advance, reuse_match;
  logic [SHIFT_WIDTH-1:0] first_chunk, next_chunk;
  logic                   last_chunk;

  assign accept = (state_q == ST_IDLE) && ready_q && dac.dac_valid;

  wl_chunk_serializer #(
    .NUM_INPUTS  (NUM_INPUTS),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .advance_i     (advance),
    .bitmap_i      (dac.wl_spike),
    .first_chunk_o (first_chunk),
    .next_chunk_o  (next_chunk),
    .last_o        (last_chunk)
  );

`ifdef WL_DAC_REUSE_EN
  logic [NUM_INPUTS-1:0] last_bitmap_q;
  logic                  last_vld_q;

  assign reuse_match = last_vld_q && (dac.wl_spike == last_bitmap_q);

  // Remember the bitmap most recently shifted into the driver chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bitmap_q <= '0;
      last_vld_q    <= 1'b0;
    end else if (accept && !reuse_match) begin
      last_bitmap_q <= dac.wl_spike;
      last_vld_q    <= 1'b1;
    end
  end
`else
  assign reuse_match = 1'b0;
`endif

  // Next-state and registered-output logic for the shift/latch/settle sequence.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    sdata_d = sdata_q;
    sclk_d  = sclk_q;
    latch_d = 1'b0;
    hit_d   = 1'b0;
    reuse_d = reuse_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          sdata_d = first_chunk;
          sclk_d  = 1'b0;
          // A reused bitmap parks in SHIFT_HI flagged as done, so the
          // latch strobe lands one edge after accept with no sclk pulses.
          reuse_d = reuse_match;
          state_d = reuse_match ? ST_SHIFT_HI : ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        sclk_d  = 1'b1;
        state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        sclk_d = 1'b0;
        if (last_chunk || reuse_q) begin
          latch_d = 1'b1;
          hit_d   = reuse_q;
          state_d = ST_LATCH;
        end else begin
          sdata_d = next_chunk;
          advance = 1'b1;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        reuse_d = 1'b0;
        if (SETTLE_CYCLES == 0) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence without a latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      sdata_q <= '0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      hit_q   <= 1'b0;
      reuse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      hit_q   <= hit_d;
      reuse_q <= reuse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dac.dac_ready  = ready_q;
  assign drv_busy       = busy_q;
  assign drv_sdata      = sdata_q;
  assign drv_sclk       = sclk_q;
  assign drv_latch      = latch_q;
  assign drv_reuse_hit  = hit_q;

endmodule
